uio_bus_arbiter: RTL and testbench
==================================

UIO_BUS_ARBITER -- requirements
Module: uio_bus_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
  N_REQ, 4, number of requesters (legal 2..8)
  MAX_HOLD, 8, maximum consecutive grant cycles per ownership (legal 1..256)
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock, all state on rising edge
  rst  in  1  reset, asynchronous, active-high
  ena  in  1  design enable; 0 blocks new grants
  req  in  N_REQ  request per requester, level-sensitive
  req_data  in  8*N_REQ  requester i drives uio value on bits [8i+7:8i]
  req_oe  in  8*N_REQ  requester i output-enable on bits [8i+7:8i]
  grant  out  N_REQ  one-hot registered grant, all-zero when none
  owner  out  3  index of current owner, 0 when none
  busy  out  1  1 while a grant is held
  uio_out  out  8  shared bus value
  uio_oe  out  8  shared bus enable, 1 = output

Function
REQ-003 The FSM SHALL have exactly the states IDLE, OWN and TURN.
REQ-004 IDLE: grant=0, uio_oe=0; if ena=1 and any req bit is set, the next cycle SHALL be OWN with grant set to the round-robin winner.
REQ-005 Arbitration SHALL pick the first set req bit at or above the rotation pointer ptr, wrapping modulo N_REQ.
REQ-006 Grant latency SHALL be one cycle: req sampled high at edge n gives grant at edge n+1.
REQ-007 OWN: uio_out SHALL equal req_data of the owner, and uio_oe SHALL equal req_oe of the owner ANDed with req[owner], both combinational from the registered grant.
REQ-008 OWN: the hold counter SHALL start at 0 on entry and increment each cycle; its width is clog2(MAX_HOLD), minimum 1.
REQ-009 OWN SHALL exit to TURN at the first edge where any of these hold: req[owner]=0; the counter equals MAX_HOLD-1; ena=0.
REQ-010 On exit from OWN, ptr SHALL become (owner+1) mod N_REQ, so a forced release passes priority to the next requester.
REQ-011 TURN SHALL last exactly one cycle with grant=0 and uio_oe=0, and uio_out SHALL equal 0.
REQ-012 From TURN: if ena=1 and any req bit is set, the next state SHALL be OWN with a new winner; otherwise the next state SHALL be IDLE.
REQ-013 A single requester that holds req continuously SHALL get MAX_HOLD grant cycles, then one TURN cycle, then be regranted.
REQ-014 busy SHALL equal 1 exactly in OWN, and owner SHALL be the encoded grant.
REQ-015 Two ownerships SHALL never be back-to-back without a TURN cycle between them, so that uio_oe contention cannot occur.
REQ-016 req changes on non-owner bits SHALL have no effect until the next arbitration point (IDLE or TURN).

Reset
REQ-017 While rst=1, asynchronously: state=IDLE, ptr=0, hold counter=0, grant=0, owner=0, busy=0, uio_out=0, uio_oe=0.
REQ-018 Reset asserted mid-ownership SHALL drop grant and uio_oe in the same cycle, without waiting for a clock edge.
REQ-019 In the first edge after rst deasserts, requester 0 SHALL have highest priority.

Structure
REQ-020 A shared package uio_arb_pkg SHALL hold the state enum, the default values of N_REQ and MAX_HOLD, and the bus width constant (8).
REQ-021 The round-robin priority selection SHALL be one combinational sub-module, rr_pick (inputs: req vector, ptr; outputs: one-hot winner, valid).
REQ-022 Elaboration SHALL fail if N_REQ or MAX_HOLD is outside its legal range.

Verification
REQ-023 The bench SHALL cover these directed scenarios (N_REQ=4, MAX_HOLD=8 unless stated):
  - After reset, req=4'b1111 -> grant=0001 at the next edge; sequence 0,1,2,3,0, each ownership 8 cycles, each followed by one TURN cycle with uio_oe=0.
  - req[2] alone for 3 cycles, with req_data[2]=8'hA5 and req_oe[2]=8'hFF -> uio_out=A5 and uio_oe=FF for 3 cycles; then TURN; then IDLE; busy low.
  - req[1] held continuously, MAX_HOLD=4 -> a pattern of 4 OWN cycles and 1 TURN cycle repeats; grant is never 0 for more than 1 cycle.
  - ena dropped mid-OWN -> TURN at the next edge, then IDLE while req stays high; grant resumes one cycle after ena returns to 1.
  - rst pulsed between clock edges during OWN -> grant, uio_oe and busy go to 0 immediately; after release, req=4'b1010 -> grant=0010.
  - Assertions over random req/ena traffic: grant is always one-hot or zero; uio_oe=0 whenever grant=0; no OWN-to-OWN transition without TURN.

Source files
------------

// File: rtl/uio_arb_pkg.sv
// Shared constants and state encoding for the uio bus arbiter.
// Holds the bus width and the default arbiter sizing.
package uio_arb_pkg;

    localparam int BUS_W        = 8;
    localparam int DEF_N_REQ    = 4;
    localparam int DEF_MAX_HOLD = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_e;

endpackage

// File: rtl/uio_bus_arbiter_rr_pick.sv
// Round-robin priority pick: the first set request at or above ptr, wrapping.
// Purely combinational; winner is one-hot, or all-zero when no request is set.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic          valid
);

    logic [PW:0] idx;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        winner = '0;
        idx    = '0;
        valid  = |req;
        // Scan from farthest to nearest so the request closest to ptr overwrites the rest.
        for (int k = N - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (PW + 1)'(k);
            if (idx >= (PW + 1)'(N)) begin
                idx = idx - (PW + 1)'(N);
            end
            if (req[idx[PW-1:0]]) begin
                winner                = '0;
                winner[idx[PW-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of a shared 8-bit uio bus with a bounded hold time
// and a mandatory one-cycle turnaround between ownerships.
module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic [N_REQ-1:0]       req,
    input  logic [BUS_W*N_REQ-1:0] req_data,
    input  logic [BUS_W*N_REQ-1:0] req_oe,
    output logic [N_REQ-1:0]       grant,
    output logic [2:0]             owner,
    output logic                   busy,
    output logic [BUS_W-1:0]       uio_out,
    output logic [BUS_W-1:0]       uio_oe
);

    localparam int PTR_W  = $clog2(N_REQ);
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("uio_bus_arbiter: N_REQ must be in 2..8");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 256) begin : g_bad_max_hold
        $error("uio_bus_arbiter: MAX_HOLD must be in 1..256");
    end

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [N_REQ-1:0]   grant_q, grant_d;

    logic [N_REQ-1:0]   pick_onehot;
    logic               pick_valid;
    logic [PTR_W-1:0]   owner_idx;
    logic               release_own;

    rr_pick #(
        .N  (N_REQ),
        .PW (PTR_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (pick_onehot),
        .valid  (pick_valid)
    );

    // Outputs derive from the registered grant so an async reset clears them at once.
    always_comb begin
        owner_idx = '0;
        uio_out   = '0;
        uio_oe    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                owner_idx = PTR_W'(i);
                uio_out   = req_data[i*BUS_W +: BUS_W];
                uio_oe    = req_oe[i*BUS_W +: BUS_W] & {BUS_W{req[i]}};
            end
        end
    end

    assign grant = grant_q;
    assign owner = 3'(owner_idx);
    assign busy  = (state_q == OWN);

    assign release_own = !req[owner_idx] || (hold_q == HOLD_W'(MAX_HOLD - 1)) || !ena;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        case (state_q)
            IDLE, TURN: begin
                hold_d  = '0;
                grant_d = '0;
                state_d = IDLE;
                if (ena && pick_valid) begin
                    state_d = OWN;
                    grant_d = pick_onehot;
                end
            end
            OWN: begin
                if (release_own) begin
                    state_d = TURN;
                    grant_d = '0;
                    hold_d  = '0;
                    ptr_d   = (owner_idx == PTR_W'(N_REQ - 1)) ? '0 : owner_idx + PTR_W'(1);
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                hold_d  = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
        end
    end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter: round-robin order, hold limit, turnaround,
// enable gating, async reset and invariants under random traffic.
module tb_uio_bus_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           ena;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [8*N-1:0] req_oe;

    logic [N-1:0]   grant,  grant4;
    logic [2:0]     owner,  owner4;
    logic           busy,   busy4;
    logic [7:0]     uio_out, uio_out4;
    logic [7:0]     uio_oe,  uio_oe4;

    int errors = 0;
    int checks = 0;

    uio_bus_arbiter #(.N_REQ(4), .MAX_HOLD(8)) dut (
        .clk(clk), .rst(rst), .ena(ena), .req(req), .req_data(req_data), .req_oe(req_oe),
        .grant(grant), .owner(owner), .busy(busy), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    uio_bus_arbiter #(.N_REQ(4), .MAX_HOLD(4)) dut4 (
        .clk(clk), .rst(rst), .ena(ena), .req(req), .req_data(req_data), .req_oe(req_oe),
        .grant(grant4), .owner(owner4), .busy(busy4), .uio_out(uio_out4), .uio_oe(uio_oe4)
    );

    always #5 clk = ~clk;

    wire [23:0] obs  = {grant,  owner,  busy,  uio_out,  uio_oe};
    wire [23:0] obs4 = {grant4, owner4, busy4, uio_out4, uio_oe4};

    function automatic logic [23:0] pk(input logic [3:0] g, input logic [2:0] o, input logic b,
                                       input logic [7:0] d, input logic [7:0] e);
        return {g, o, b, d, e};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b0; req = '0;
        #1;
        checks++;
        if (obs !== 24'h0 || obs4 !== 24'h0) begin
            errors++;
            $display("FAIL reset_async: got %h/%h want 000000", obs, obs4);
        end
        tick();
        tick();
        checks++;
        if (obs !== 24'h0) begin
            errors++;
            $display("FAIL reset_held: got %h want 000000", obs);
        end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [23:0] exp;
        test_reset();
        req_data = 32'h44_33_22_11;
        req_oe   = 32'hF0_0F_FF_3C;
        ena = 1'b1;
        req = 4'b1111;
        tick();
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 8; c++) begin
                exp = pk(4'(1 << k), 3'(k), 1'b1, req_data[8*k +: 8], req_oe[8*k +: 8]);
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL rr_own k=%0d c=%0d: got %h want %h", k, c, obs, exp);
                end
                tick();
            end
            checks++;
            if (obs !== 24'h0) begin
                errors++;
                $display("FAIL rr_turn k=%0d: got %h want 000000", k, obs);
            end
            tick();
        end
        exp = pk(4'b0001, 3'd0, 1'b1, 8'h11, 8'h3C);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL rr_wrap: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_single_short();
        logic [23:0] exp;
        test_reset();
        req_data = 32'h00_A5_00_00;
        req_oe   = 32'h00_FF_00_00;
        ena = 1'b1;
        req = 4'b0100;
        tick();
        exp = pk(4'b0100, 3'd2, 1'b1, 8'hA5, 8'hFF);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL short_own c=%0d: got %h want %h", c, obs, exp);
            end
            if (c == 2) req = '0;
            tick();
        end
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (obs !== 24'h0) begin
                errors++;
                $display("FAIL short_release c=%0d: got %h want 000000", c, obs);
            end
            tick();
        end
    endtask

    task automatic test_hold_limit();
        logic [23:0] exp;
        test_reset();
        req_data = 32'h00_00_5A_00;
        req_oe   = 32'h00_00_C3_00;
        ena = 1'b1;
        req = 4'b0010;
        tick();
        exp = pk(4'b0010, 3'd1, 1'b1, 8'h5A, 8'hC3);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (obs4 !== exp) begin
                    errors++;
                    $display("FAIL hold4_own r=%0d c=%0d: got %h want %h", r, c, obs4, exp);
                end
                tick();
            end
            checks++;
            if (obs4 !== 24'h0) begin
                errors++;
                $display("FAIL hold4_turn r=%0d: got %h want 000000", r, obs4);
            end
            tick();
        end
        checks++;
        if (obs4 !== exp) begin
            errors++;
            $display("FAIL hold4_regrant: got %h want %h", obs4, exp);
        end
    endtask

    task automatic test_enable_drop();
        logic [23:0] exp;
        test_reset();
        req_data = 32'h00_00_00_77;
        req_oe   = 32'h00_00_00_0F;
        exp = pk(4'b0001, 3'd0, 1'b1, 8'h77, 8'h0F);
        ena = 1'b1;
        req = 4'b0001;
        tick();
        tick();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL ena_own: got %h want %h", obs, exp);
        end
        ena = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (obs !== 24'h0) begin
                errors++;
                $display("FAIL ena_blocked c=%0d: got %h want 000000", c, obs);
            end
        end
        ena = 1'b1;
        tick();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL ena_resume: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_async_reset();
        logic [23:0] exp;
        test_reset();
        req_data = 32'h44_33_22_11;
        req_oe   = 32'hFF_FF_FF_FF;
        ena = 1'b1;
        req = 4'b0100;
        tick();
        exp = pk(4'b0100, 3'd2, 1'b1, 8'h33, 8'hFF);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL arst_own: got %h want %h", obs, exp);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 24'h0) begin
            errors++;
            $display("FAIL arst_drop: got %h want 000000", obs);
        end
        #3 rst = 1'b0;
        req = 4'b1010;
        tick();
        exp = pk(4'b0010, 3'd1, 1'b1, 8'h22, 8'hFF);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL arst_prio: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_no_preempt();
        logic [23:0] exp;
        test_reset();
        req_data = 32'h00_00_BB_AA;
        req_oe   = 32'h00_00_E7_3C;
        ena = 1'b1;
        req = 4'b0001;
        tick();
        req = 4'b0011;
        exp = pk(4'b0001, 3'd0, 1'b1, 8'hAA, 8'h3C);
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL keep_owner c=%0d: got %h want %h", c, obs, exp);
            end
        end
        req = 4'b0010;
        #1;
        exp = pk(4'b0001, 3'd0, 1'b1, 8'hAA, 8'h00);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL oe_masked: got %h want %h", obs, exp);
        end
        tick();
        checks++;
        if (obs !== 24'h0) begin
            errors++;
            $display("FAIL handoff_turn: got %h want 000000", obs);
        end
        tick();
        exp = pk(4'b0010, 3'd1, 1'b1, 8'hBB, 8'hE7);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL handoff_next: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_random_traffic();
        logic [N-1:0] prev_grant;
        int           run;
        logic [2:0]   enc;
        test_reset();
        prev_grant = '0;
        run = 0;
        for (int n = 0; n < 300; n++) begin
            req      = N'($urandom);
            ena      = ($urandom_range(0, 7) != 0);
            req_data = $urandom;
            req_oe   = $urandom;
            tick();
            enc = '0;
            for (int i = 0; i < N; i++) if (grant[i]) enc = 3'(i);
            run = (grant != 0 && grant == prev_grant) ? run + 1 : ((grant != 0) ? 1 : 0);
            checks++;
            if ((grant & (grant - 1'b1)) != 0 || busy !== (grant != 0) || owner !== enc) begin
                errors++;
                $display("FAIL rnd_grant n=%0d: got g=%b o=%0d b=%b want onehot0, busy=|g, owner=%0d",
                         n, grant, owner, busy, enc);
            end
            checks++;
            if (grant == 0 && (uio_oe !== 8'h00 || uio_out !== 8'h00)) begin
                errors++;
                $display("FAIL rnd_idle_bus n=%0d: got out=%h oe=%h want 00/00", n, uio_out, uio_oe);
            end
            checks++;
            if ((prev_grant != 0 && grant != 0 && grant != prev_grant) || run > 8) begin
                errors++;
                $display("FAIL rnd_turn n=%0d: got prev=%b now=%b run=%0d want TURN between, run<=8",
                         n, prev_grant, grant, run);
            end
            prev_grant = grant;
        end
        req = '0;
        ena = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; req = '0; req_data = '0; req_oe = '0;
        test_reset();
        test_round_robin();
        test_single_short();
        test_hold_limit();
        test_enable_drop();
        test_async_reset();
        test_no_preempt();
        test_random_traffic();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
